// File: rtl/ascon_serial_io.sv
// Serial-to-parallel front end for an Ascon AEAD core: deserialises key/nonce/AD/data(/tag)
// beats, launches the core, then serialises the result (data+tag, or tag-gated plaintext).
module ascon_serial_io #(
  parameter int LANES      = 8,
  parameter int BLOCK_BITS = 64,
  parameter int TIMEOUT    = 1023
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sof_i,
  input  logic                  decrypt_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [LANES-1:0]      in_data_i,
  output logic [127:0]          core_key_o,
  output logic [127:0]          core_nonce_o,
  output logic [BLOCK_BITS-1:0] core_ad_o,
  output logic [BLOCK_BITS-1:0] core_data_o,
  output logic                  core_decrypt_o,
  output logic                  core_start_o,
  input  logic                  core_done_i,
  input  logic [BLOCK_BITS-1:0] core_data_i,
  input  logic [127:0]          core_tag_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [LANES-1:0]      out_data_o,
  output logic                  out_last_o,
  output logic                  busy_o,
  output logic                  tag_ok_o,
  output logic                  err_timeout_o
);

  localparam int MAIN_W    = 256 + 2 * BLOCK_BITS;
  localparam int OUT_W     = BLOCK_BITS + 128;
  localparam int N_ENC     = MAIN_W / LANES;
  localparam int N_DEC     = (MAIN_W + 128) / LANES;
  localparam int N_OUT_ENC = OUT_W / LANES;
  localparam int N_OUT_DEC = BLOCK_BITS / LANES;
  localparam int CW        = $clog2(N_DEC + 1);
  localparam int OW        = $clog2(N_OUT_ENC + 1);
  localparam int TW        = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT,
    UNLOAD
  } state_t;

  state_t              state, state_n;
  logic [MAIN_W-1:0]   main_sr;
  logic [127:0]        tag_sr;
  logic [OUT_W-1:0]    out_sr;
  logic [CW-1:0]       beat_cnt;
  logic [OW-1:0]       out_cnt;
  logic [TW-1:0]       timer;
  logic                decrypt_q;
  logic                tag_ok_q;
  logic                err_q;

  logic accept;
  logic in_last;
  logic out_last;
  logic timed_out;
  logic tag_match;

  always_comb begin
    in_ready_o = (state == IDLE) || (state == LOAD);
    accept     = in_valid_i && in_ready_o;
    in_last    = beat_cnt == (decrypt_q ? CW'(N_DEC - 1) : CW'(N_ENC - 1));
    out_last   = out_cnt == (decrypt_q ? OW'(N_OUT_DEC - 1) : OW'(N_OUT_ENC - 1));
    timed_out  = timer == TW'(TIMEOUT - 1);
    tag_match  = core_tag_i == tag_sr;
  end

  // Key/nonce/AD/data share one shift register so each field fills MSB first
  // and settles in place once the frame is complete.
  assign core_key_o     = main_sr[MAIN_W-1 -: 128];
  assign core_nonce_o   = main_sr[2*BLOCK_BITS+127 -: 128];
  assign core_ad_o      = main_sr[2*BLOCK_BITS-1 -: BLOCK_BITS];
  assign core_data_o    = main_sr[BLOCK_BITS-1:0];
  assign core_decrypt_o = decrypt_q;
  assign core_start_o   = (state == START);
  assign out_valid_o    = (state == UNLOAD);
  assign out_data_o     = out_valid_o ? out_sr[OUT_W-1 -: LANES] : '0;
  assign out_last_o     = out_valid_o && out_last;
  assign busy_o         = (state != IDLE);
  assign tag_ok_o       = tag_ok_q;
  assign err_timeout_o  = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept && sof_i) state_n = LOAD;
      LOAD:    if (accept && !sof_i && in_last) state_n = START;
      START:   state_n = WAIT;
      WAIT: begin
        if (core_done_i)    state_n = UNLOAD;
        else if (timed_out) state_n = IDLE;
      end
      UNLOAD:  if (out_ready_i && out_last) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_sr   <= '0;
      tag_sr    <= '0;
      out_sr    <= '0;
      beat_cnt  <= '0;
      out_cnt   <= '0;
      timer     <= '0;
      decrypt_q <= 1'b0;
      tag_ok_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        IDLE, LOAD: begin
          if (accept && sof_i) begin
            decrypt_q <= decrypt_i;
            main_sr   <= {main_sr[MAIN_W-LANES-1:0], in_data_i};
            beat_cnt  <= CW'(1);
            tag_ok_q  <= 1'b0;
            err_q     <= 1'b0;
          end else if (accept && state == LOAD) begin
            // Beats past the encrypt-frame length can only be the received tag.
            if (beat_cnt < CW'(N_ENC)) main_sr <= {main_sr[MAIN_W-LANES-1:0], in_data_i};
            else                       tag_sr  <= {tag_sr[127-LANES:0], in_data_i};
            beat_cnt <= beat_cnt + CW'(1);
          end
        end
        START: timer <= '0;
        WAIT: begin
          if (core_done_i) begin
            tag_ok_q <= decrypt_q && tag_match;
            out_cnt  <= '0;
            if (decrypt_q)
              out_sr <= {(tag_match ? core_data_i : {BLOCK_BITS{1'b0}}), 128'b0};
            else
              out_sr <= {core_data_i, core_tag_i};
          end else if (timed_out) begin
            err_q <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        UNLOAD: begin
          if (out_ready_i) begin
            out_sr  <= {out_sr[OUT_W-LANES-1:0], {LANES{1'b0}}};
            out_cnt <= out_cnt + OW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ascon_serial_io.sv
// Scoreboard bench for ascon_serial_io (LANES=8, BLOCK_BITS=64): the bench plays the core
// and predicts every output beat when it delivers core results.
module tb_ascon_serial_io;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sof_i = 1'b0;
  logic         decrypt_i = 1'b0;
  logic         in_valid_i = 1'b0;
  logic         in_ready_o;
  logic [7:0]   in_data_i = '0;
  logic [127:0] core_key_o, core_nonce_o;
  logic [63:0]  core_ad_o, core_data_o;
  logic         core_decrypt_o, core_start_o;
  logic         core_done_i = 1'b0;
  logic [63:0]  core_data_i = '0;
  logic [127:0] core_tag_i = '0;
  logic         out_valid_o;
  logic         out_ready_i = 1'b1;
  logic [7:0]   out_data_o;
  logic         out_last_o, busy_o, tag_ok_o, err_timeout_o;

  int total = 0;
  int bad = 0;
  int starts = 0;
  bit toggle_rdy = 1'b0;
  logic [8:0] sb[$];

  ascon_serial_io #(.LANES(8), .BLOCK_BITS(64), .TIMEOUT(1023)) dut (
    .clk(clk), .rst(rst), .sof_i(sof_i), .decrypt_i(decrypt_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .core_key_o(core_key_o), .core_nonce_o(core_nonce_o), .core_ad_o(core_ad_o),
    .core_data_o(core_data_o), .core_decrypt_o(core_decrypt_o), .core_start_o(core_start_o),
    .core_done_i(core_done_i), .core_data_i(core_data_i), .core_tag_i(core_tag_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .out_last_o(out_last_o), .busy_o(busy_o), .tag_ok_o(tag_ok_o), .err_timeout_o(err_timeout_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Outputs are sampled on the falling edge; a beat with ready high there is consumed next rise.
  always @(negedge clk) begin
    if (core_start_o) starts++;
    if (out_valid_o) begin
      if (sb.size() == 0) check("unexpected_out", 128'(sb.size()), 128'd1);
      else begin
        check(out_ready_i ? "out_beat" : "out_hold", 128'({out_last_o, out_data_o}), 128'(sb[0]));
        if (out_ready_i) void'(sb.pop_front());
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    out_ready_i = toggle_rdy ? ~out_ready_i : 1'b1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [127:0] seq(input int start, input int n);
    logic [127:0] v = '0;
    for (int i = 0; i < n; i++) v = (v << 8) | 128'((start + i) & 255);
    return v;
  endfunction

  task automatic send_beats(input logic dec, input logic [511:0] fr, input int count);
    for (int i = 0; i < count; i++) begin
      in_valid_i = 1'b1;
      sof_i      = (i == 0);
      decrypt_i  = dec;
      in_data_i  = fr[511 - 8*i -: 8];
      @(posedge clk); #1;
    end
    in_valid_i = 1'b0;
    sof_i      = 1'b0;
  endtask

  task automatic push_out(input logic dec, input logic ok, input logic [63:0] d, input logic [127:0] t);
    logic [191:0] v;
    int n;
    v = dec ? {(ok ? d : 64'h0), 128'h0} : {d, t};
    n = dec ? 8 : 24;
    for (int i = 0; i < n; i++) sb.push_back({(i == n - 1), v[191 - 8*i -: 8]});
  endtask

  task automatic wait_drain(input string nm, input int limit);
    int n = 0;
    while ((busy_o || sb.size() != 0) && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    check({nm, "_drain"}, 128'(n < limit), 128'd1);
  endtask

  task automatic run_frame(input string nm, input logic dec,
                           input logic [127:0] key, input logic [127:0] nonce,
                           input logic [63:0] ad, input logic [63:0] data,
                           input logic [127:0] rx_tag,
                           input logic [63:0] cd, input logic [127:0] ct);
    logic ok;
    ok = dec && (ct == rx_tag);
    starts = 0;
    send_beats(dec, {key, nonce, ad, data, rx_tag}, dec ? 64 : 48);
    check({nm, "_start"}, 128'(core_start_o), 128'd1);
    check({nm, "_key"}, core_key_o, key);
    check({nm, "_nonce"}, core_nonce_o, nonce);
    check({nm, "_ad"}, 128'(core_ad_o), 128'(ad));
    check({nm, "_data"}, 128'(core_data_o), 128'(data));
    check({nm, "_mode"}, 128'(core_decrypt_o), 128'(dec));
    repeat (4) @(posedge clk);
    #1;
    core_done_i = 1'b1;
    core_data_i = cd;
    core_tag_i  = ct;
    push_out(dec, ok, cd, ct);
    @(posedge clk); #1;
    core_done_i = 1'b0;
    check({nm, "_tag_ok"}, 128'(tag_ok_o), 128'(ok));
    wait_drain(nm, 200);
    check({nm, "_starts"}, 128'(starts), 128'd1);
    check({nm, "_idle"}, 128'(busy_o), 128'd0);
    check({nm, "_tag_ok_hold"}, 128'(tag_ok_o), 128'(ok));
    check({nm, "_key_hold"}, core_key_o, key);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [127:0] k, n, t, ct, tmp;
    logic [63:0] a, d, cd;
    int cyc;

    // Reset: a valid sof beat offered during reset must not be taken.
    rst = 1'b1;
    in_valid_i = 1'b1;
    sof_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 128'(in_ready_o), 128'd1);
    check("rst_busy", 128'(busy_o), 128'd0);
    check("rst_out_valid", 128'(out_valid_o), 128'd0);
    check("rst_key", core_key_o, 128'd0);
    check("rst_flags", 128'({err_timeout_o, tag_ok_o, core_start_o, out_last_o}), 128'd0);
    check("rst_out_data", 128'(out_data_o), 128'd0);
    in_valid_i = 1'b0;
    sof_i = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_no_accept", 128'(busy_o), 128'd0);

    // Beats without sof in IDLE are dropped.
    in_valid_i = 1'b1;
    in_data_i = 8'h55;
    repeat (3) @(posedge clk);
    #1;
    in_valid_i = 1'b0;
    check("drop_nosof", 128'(busy_o), 128'd0);

    // Encrypt with byte-ramp fields.
    k = seq(0, 16); n = seq(16, 16);
    tmp = seq(32, 8); a = tmp[63:0];
    tmp = seq(48, 8); d = tmp[63:0];
    tmp = seq(160, 8); cd = tmp[63:0];
    ct = seq(176, 16);
    run_frame("enc", 1'b0, k, n, a, d, 128'h0, cd, ct);

    // Decrypt, matching tag, with out_ready toggling.
    toggle_rdy = 1'b1;
    k = seq(64, 16); n = seq(80, 16);
    tmp = seq(96, 8); a = tmp[63:0];
    tmp = seq(104, 8); d = tmp[63:0];
    t = seq(192, 16);
    tmp = seq(144, 8); cd = tmp[63:0];
    run_frame("dec_ok", 1'b1, k, n, a, d, t, cd, t);

    // Decrypt, core tag differs in one bit: zeroed output.
    run_frame("dec_bad", 1'b1, k, n, a, d, t, cd, t ^ 128'h1);
    toggle_rdy = 1'b0;
    @(posedge clk); #1;

    // Timeout: no core_done_i at all.
    starts = 0;
    k = seq(0, 16); n = seq(16, 16);
    tmp = seq(32, 8); a = tmp[63:0];
    tmp = seq(48, 8); d = tmp[63:0];
    send_beats(1'b0, {k, n, a, d, 128'h0}, 48);
    cyc = 0;
    while (busy_o && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("to_cycles", 128'(cyc), 128'd1024);
    check("to_err", 128'(err_timeout_o), 128'd1);
    check("to_starts", 128'(starts), 128'd1);
    send_beats(1'b0, {k, n, a, d, 128'h0}, 1);
    check("to_err_clear", 128'(err_timeout_o), 128'd0);
    check("to_busy_after_sof", 128'(busy_o), 128'd1);
    do_reset();

    // Restart: 20 beats of one frame, then a fresh frame from sof.
    tmp = seq(224, 16);
    send_beats(1'b0, {tmp, tmp, 64'hFFFF_FFFF_FFFF_FFFF, 64'hEEEE_EEEE_EEEE_EEEE, 128'h0}, 20);
    k = seq(112, 16);
    tmp = seq(160, 8); cd = tmp[63:0];
    ct = seq(176, 16);
    run_frame("restart", 1'b0, k, n, a, d, 128'h0, cd, ct);

    // Reset during WAIT, then a late core_done_i.
    starts = 0;
    send_beats(1'b0, {k, n, a, d, 128'h0}, 48);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rstw_busy", 128'(busy_o), 128'd0);
    check("rstw_key", core_key_o, 128'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    starts = 0;
    repeat (3) @(posedge clk);
    #1;
    core_done_i = 1'b1;
    core_data_i = cd;
    core_tag_i = ct;
    @(posedge clk); #1;
    core_done_i = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("rstw_starts", 128'(starts), 128'd0);
    check("rstw_idle", 128'({busy_o, out_valid_o, tag_ok_o, err_timeout_o}), 128'd0);
    check("rstw_data", 128'(core_data_o), 128'd0);
    check("rstw_sb", 128'(sb.size()), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
